// File: rtl/serial_logic_engine.sv
// Bit-serial bitwise logic engine that drives a single 1-bit logicunit, LSB first.
// Optional zero-result flag port is enabled by defining SERIAL_LOGIC_ZERO_FLAG_EN.

module logicunit (
  input  logic       a_i,
  input  logic       b_i,
  input  logic [1:0] control_i,
  output logic       y_o
);

  // 0=AND, 1=OR, 2=NOR, 3=XOR
  always_comb begin
    y_o = 1'b0;
    case (control_i)
      2'd0: y_o = a_i & b_i;
      2'd1: y_o = a_i | b_i;
      2'd2: y_o = ~(a_i | b_i);
      2'd3: y_o = a_i ^ b_i;
      default: y_o = 1'b0;
    endcase
  end

endmodule

module serial_logic_engine #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             busy
`ifdef SERIAL_LOGIC_ZERO_FLAG_EN
  ,
  output logic             zero
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [1:0]       ctl_q, ctl_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] shifted;
  logic             bitRes;

  logicunit u_logicunit (
    .a_i       (a_q[cnt_q]),
    .b_i       (b_q[cnt_q]),
    .control_i (ctl_q),
    .y_o       (bitRes)
  );

  // New bits enter at the MSB so that after WIDTH shifts bit 0 lands at index 0.
  generate
    if (WIDTH == 1) begin : g_shift_one
      assign shifted = bitRes;
    end else begin : g_shift_many
      assign shifted = {bitRes, res_q[WIDTH-1:1]};
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    ctl_d   = ctl_q;
    res_d   = res_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = A;
          b_d     = B;
          ctl_d   = control;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        res_d = shifted;
        if (cnt_q == LAST) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      ctl_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ctl_q   <= ctl_d;
      res_q   <= res_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == RUN);
  assign out_valid = (state_q == DONE);
  assign out       = res_q;

`ifdef SERIAL_LOGIC_ZERO_FLAG_EN
  logic zflag_q, zflag_d;

  // Flag starts true on accept and drops on the first 1 shifted in.
  always_comb begin
    zflag_d = zflag_q;
    if (state_q == IDLE && in_valid) begin
      zflag_d = 1'b1;
    end else if (state_q == RUN && bitRes) begin
      zflag_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      zflag_q <= 1'b0;
    end else begin
      zflag_q <= zflag_d;
    end
  end

  assign zero = zflag_q && out_valid;
`endif

endmodule
